// File: rtl/fpmodulus_seq.sv
// Purpose: sign-magnitude fixed-point fmod (remainder keeps dividend sign) plus truncated quotient, restoring shift-subtract.
// Latency: start sampled at edge k -> donefmod and results at edge k+N+2 (k+3 on divide by zero); fixed, operand independent.
// Backpressure: none; startfmod is ignored while busy, nothing is queued, a held start re-launches on the first IDLE cycle.
module fpmodulus_seq #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         startfmod,
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  output logic [N-1:0] mod,
  output logic [N-1:0] quot,
  output logic         div_zero,
  output logic         busy,
  output logic         donefmod
);

  // Q only changes how the bits are read, never the datapath; this guard just
  // names the legal range (at least the sign bit must stay outside the fraction).
  if (Q > N - 1) begin : g_q_out_of_range
  end

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched operands (full sign-magnitude words)
  logic [N-1:0]  n1_q, n1_d;
  logic [N-1:0]  n2_q, n2_d;
  // Magnitudes: ma is shifted left as its bits are consumed MSB first
  logic [N-2:0]  ma_q, ma_d;
  logic [N-2:0]  mb_q, mb_d;
  // Partial remainder and quotient bits being accumulated
  logic [N-1:0]  r_q, r_d;
  logic [N-2:0]  qb_q, qb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // LOAD runs two phases: capture magnitudes, then decide on the registered divisor
  logic          load_ph_q, load_ph_d;
  logic          zero_q, zero_d;
  // Registered results
  logic [N-1:0]  mod_q, mod_d;
  logic [N-1:0]  quot_q, quot_d;
  logic          dz_q, dz_d;

  // One restoring step: trial value is the remainder shifted with the next dividend bit
  logic [N:0]    trial;
  logic [N-1:0]  trial_diff;
  logic          trial_ge;

  always_comb begin
    trial      = {r_q, ma_q[N-2]};
    trial_ge   = (trial >= {2'b00, mb_q});
    trial_diff = trial[N-1:0] - {1'b0, mb_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (startfmod) state_d = S_LOAD;
      S_LOAD: begin
        if (load_ph_q) begin
          state_d = (mb_q == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: if (cnt_q == LAST_ITER) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values, advanced according to the current state
  always_comb begin
    n1_d      = n1_q;
    n2_d      = n2_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    r_d       = r_q;
    qb_d      = qb_q;
    cnt_d     = cnt_q;
    load_ph_d = load_ph_q;
    zero_d    = zero_q;
    mod_d     = mod_q;
    quot_d    = quot_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (startfmod) begin
          n1_d = num1;
          n2_d = num2;
        end
      end
      S_LOAD: begin
        if (!load_ph_q) begin
          ma_d      = n1_q[N-2:0];
          mb_d      = n2_q[N-2:0];
          r_d       = '0;
          qb_d      = '0;
          cnt_d     = '0;
          load_ph_d = 1'b1;
        end else begin
          load_ph_d = 1'b0;
          zero_d    = (mb_q == '0);
        end
      end
      S_CALC: begin
        r_d   = trial_ge ? trial_diff : trial[N-1:0];
        qb_d  = {qb_q[N-3:0], trial_ge};
        ma_d  = {ma_q[N-3:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
      end
      S_FIX: begin
        if (zero_q) begin
          // Divide by zero passes the dividend through, minus any negative zero
          mod_d  = {n1_q[N-1] & (|n1_q[N-2:0]), n1_q[N-2:0]};
          quot_d = '0;
          dz_d   = 1'b1;
        end else begin
          mod_d  = {n1_q[N-1] & (|r_q[N-2:0]), r_q[N-2:0]};
          quot_d = {(n1_q[N-1] ^ n2_q[N-1]) & (|qb_q), qb_q};
          dz_d   = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n1_q      <= '0;
      n2_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      r_q       <= '0;
      qb_q      <= '0;
      cnt_q     <= '0;
      load_ph_q <= 1'b0;
      zero_q    <= 1'b0;
      mod_q     <= '0;
      quot_q    <= '0;
      dz_q      <= 1'b0;
    end else begin
      n1_q      <= n1_d;
      n2_q      <= n2_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      r_q       <= r_d;
      qb_q      <= qb_d;
      cnt_q     <= cnt_d;
      load_ph_q <= load_ph_d;
      zero_q    <= zero_d;
      mod_q     <= mod_d;
      quot_q    <= quot_d;
      dz_q      <= dz_d;
    end
  end

  // Outputs: results straight from registers, status decoded from the state register
  always_comb begin
    mod      = mod_q;
    quot     = quot_q;
    div_zero = dz_q;
    busy     = (state_q != S_IDLE);
    donefmod = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_fpmodulus_seq.sv
// Directed-vector bench for fpmodulus_seq at N=32, Q=16.
// Expected values are hand-computed constants; latency counted from the start-sampling edge.
// Also exercises ignored restarts, mid-operation reset and a held start.
module tb_fpmodulus_seq;

  logic        clk;
  logic        rst;
  logic        startfmod;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] mod_o;
  logic [31:0] quot_o;
  logic        div_zero;
  logic        busy;
  logic        donefmod;

  int n_chk = 0;
  int n_err = 0;

  fpmodulus_seq #(.N(32), .Q(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .startfmod (startfmod),
    .num1      (num1),
    .num2      (num2),
    .mod       (mod_o),
    .quot      (quot_o),
    .div_zero  (div_zero),
    .busy      (busy),
    .donefmod  (donefmod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  // Launch one operation, scramble inputs after the start edge, check latency, results and pulse width
  task automatic run_op(input string tag, input vec_t v);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    startfmod = 1'b1;
    num1      = v.a;
    num2      = v.b;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        startfmod = 1'b0;
        num1      = $urandom;
        num2      = $urandom;
      end
      if (donefmod) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_mod"}, mod_o, v.m);
    chk({tag, "_quot"}, quot_o, v.q);
    chk({tag, "_dz"}, {31'd0, div_zero}, v.dz);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, donefmod}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    int first;
    int stamp[3];

    vecs[0]  = '{32'h00078000, 32'h00020000, 32'h00018000, 32'h00000003, 32'd0, 35};
    vecs[1]  = '{32'h80078000, 32'h00020000, 32'h80018000, 32'h80000003, 32'd0, 35};
    vecs[2]  = '{32'h00040000, 32'h80020000, 32'h00000000, 32'h80000002, 32'd0, 35};
    vecs[3]  = '{32'h000A0000, 32'h0006487E, 32'h0003B782, 32'h00000001, 32'd0, 35};
    vecs[4]  = '{32'h00010000, 32'h0006487E, 32'h00010000, 32'h00000000, 32'd0, 35};
    vecs[5]  = '{32'h00030000, 32'h80000000, 32'h00030000, 32'h00000000, 32'd1, 4};
    vecs[6]  = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'd1, 4};
    vecs[7]  = '{32'h80010000, 32'h00020000, 32'h80010000, 32'h00000000, 32'd0, 35};
    vecs[8]  = '{32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h7FFFFFFF, 32'd0, 35};
    vecs[9]  = '{32'h80000000, 32'h00010000, 32'h00000000, 32'h00000000, 32'd0, 35};
    vecs[10] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h80000001, 32'd0, 35};
    vecs[11] = '{32'h00012345, 32'h80001000, 32'h00000345, 32'h80000012, 32'd0, 35};

    rst       = 1'b0;
    startfmod = 1'b0;
    num1      = '0;
    num2      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mod", mod_o, 32'd0);
    chk("rst_quot", quot_o, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, donefmod}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 12; k++) begin
      run_op($sformatf("v%0d", k), vecs[k]);
    end

    // A second start at cycle 10 of an operation must be dropped
    pulses = 0;
    first  = 0;
    @(negedge clk);
    startfmod = 1'b1;
    num1      = 32'h00078000;
    num2      = 32'h00020000;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) startfmod = 1'b0;
      if (i == 10) begin
        startfmod = 1'b1;
        num1      = 32'h7FFFFFFF;
        num2      = 32'h00000001;
      end
      if (i == 11) startfmod = 1'b0;
      if (donefmod) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("ign_pulses", pulses, 32'd1);
    chk("ign_lat", first, 32'd35);
    chk("ign_mod", mod_o, 32'h00018000);
    chk("ign_quot", quot_o, 32'h00000003);

    // Reset at cycle 20 of an operation clears everything without waiting for an edge
    @(negedge clk);
    startfmod = 1'b1;
    num1      = 32'h000A0000;
    num2      = 32'h0006487E;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) startfmod = 1'b0;
    end
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_mod", mod_o, 32'd0);
    chk("mid_rst_quot", quot_o, 32'd0);
    chk("mid_rst_done", {31'd0, donefmod}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    run_op("fresh", vecs[3]);

    // Start held high: three back-to-back operations, 36 cycles apart
    pulses = 0;
    stamp  = '{0, 0, 0};
    @(negedge clk);
    startfmod = 1'b1;
    num1      = 32'h80078000;
    num2      = 32'h00020000;
    for (int i = 1; i <= 200 && pulses < 3; i++) begin
      @(posedge clk);
      #1;
      if (donefmod) begin
        stamp[pulses] = i;
        pulses++;
      end
    end
    startfmod = 1'b0;
    chk("b2b_pulses", pulses, 32'd3);
    chk("b2b_first", stamp[0], 32'd35);
    chk("b2b_gap1", stamp[1] - stamp[0], 32'd36);
    chk("b2b_gap2", stamp[2] - stamp[1], 32'd36);
    chk("b2b_mod", mod_o, 32'h80018000);
    chk("b2b_quot", quot_o, 32'h80000003);
    @(posedge clk);
    #1;
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
